// File: rtl/ro_sync_100_s00_axi_regs.sv
// ro_sync_100_s00_axi_regs
//   AXI4-Lite slave register bank: four read/write registers on S00_AXI,
//   exposed to the ro_sync_100 core on reg0_o..reg3_o.
//
// Ports
//   ACLK, ARESETN           clock (rising edge) and synchronous active-low reset
//   S_AXI_AW*               write address channel (one-deep buffer)
//   S_AXI_W*                write data channel (one-deep buffer)
//   S_AXI_B*                write response, always OKAY
//   S_AXI_AR*               read address channel
//   S_AXI_R*                read data, always OKAY
//   reg0_o..reg3_o          current register contents
module ro_sync_100_s00_axi_regs #(
    parameter int C_S_AXI_DATA_WIDTH = 32,
    parameter int C_S_AXI_ADDR_WIDTH = 4
) (
    input  logic                            ACLK,
    input  logic                            ARESETN,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_AWADDR,
    input  logic [2:0]                      S_AXI_AWPROT,
    input  logic                            S_AXI_AWVALID,
    output logic                            S_AXI_AWREADY,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_WDATA,
    input  logic [C_S_AXI_DATA_WIDTH/8-1:0] S_AXI_WSTRB,
    input  logic                            S_AXI_WVALID,
    output logic                            S_AXI_WREADY,
    output logic [1:0]                      S_AXI_BRESP,
    output logic                            S_AXI_BVALID,
    input  logic                            S_AXI_BREADY,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_ARADDR,
    input  logic [2:0]                      S_AXI_ARPROT,
    input  logic                            S_AXI_ARVALID,
    output logic                            S_AXI_ARREADY,
    output logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_RDATA,
    output logic [1:0]                      S_AXI_RRESP,
    output logic                            S_AXI_RVALID,
    input  logic                            S_AXI_RREADY,
    output logic [C_S_AXI_DATA_WIDTH-1:0]   reg0_o,
    output logic [C_S_AXI_DATA_WIDTH-1:0]   reg1_o,
    output logic [C_S_AXI_DATA_WIDTH-1:0]   reg2_o,
    output logic [C_S_AXI_DATA_WIDTH-1:0]   reg3_o
);

    localparam int unsigned NB = C_S_AXI_DATA_WIDTH / 8;

    logic [3:0][C_S_AXI_DATA_WIDTH-1:0] regs_q, regs_d;
    logic                               aw_full_q, aw_full_d;
    logic [1:0]                         aw_idx_q, aw_idx_d;
    logic                               w_full_q, w_full_d;
    logic [C_S_AXI_DATA_WIDTH-1:0]      w_data_q, w_data_d;
    logic [NB-1:0]                      w_strb_q, w_strb_d;
    logic                               bvalid_q, bvalid_d;
    logic                               rvalid_q, rvalid_d;
    logic [C_S_AXI_DATA_WIDTH-1:0]      rdata_q, rdata_d;
    logic                               commit;

    // Protection bits and byte-offset address bits carry no meaning here.
    logic unused_inputs;
    assign unused_inputs = ^{S_AXI_AWPROT, S_AXI_ARPROT, S_AXI_AWADDR[1:0], S_AXI_ARADDR[1:0]};

    // Readies depend only on state so the master never sees a VALID->READY loop.
    assign S_AXI_AWREADY = !aw_full_q && !bvalid_q;
    assign S_AXI_WREADY  = !w_full_q && !bvalid_q;
    assign S_AXI_ARREADY = !rvalid_q;
    assign S_AXI_BVALID  = bvalid_q;
    assign S_AXI_BRESP   = 2'b00;
    assign S_AXI_RVALID  = rvalid_q;
    assign S_AXI_RDATA   = rdata_q;
    assign S_AXI_RRESP   = 2'b00;

    assign reg0_o = regs_q[0];
    assign reg1_o = regs_q[1];
    assign reg2_o = regs_q[2];
    assign reg3_o = regs_q[3];

    // Both halves of a write are buffered; commit only once both are present
    // and the previous response has been taken.
    assign commit = aw_full_q && w_full_q && !bvalid_q;

    always_comb begin
        regs_d    = regs_q;
        aw_full_d = aw_full_q;
        aw_idx_d  = aw_idx_q;
        w_full_d  = w_full_q;
        w_data_d  = w_data_q;
        w_strb_d  = w_strb_q;
        bvalid_d  = bvalid_q;
        rvalid_d  = rvalid_q;
        rdata_d   = rdata_q;

        // Write path
        if (commit) begin
            for (int unsigned n = 0; n < NB; n++) begin
                if (w_strb_q[n]) begin
                    regs_d[aw_idx_q][8*n +: 8] = w_data_q[8*n +: 8];
                end
            end
            bvalid_d  = 1'b1;
            aw_full_d = 1'b0;
            w_full_d  = 1'b0;
        end
        if (S_AXI_AWVALID && S_AXI_AWREADY) begin
            aw_full_d = 1'b1;
            aw_idx_d  = S_AXI_AWADDR[3:2];
        end
        if (S_AXI_WVALID && S_AXI_WREADY) begin
            w_full_d = 1'b1;
            w_data_d = S_AXI_WDATA;
            w_strb_d = S_AXI_WSTRB;
        end
        if (bvalid_q && S_AXI_BREADY) begin
            bvalid_d = 1'b0;
        end

        // Read path: samples pre-edge register values, so a same-edge commit
        // to the same index is not visible to this read.
        if (rvalid_q && S_AXI_RREADY) begin
            rvalid_d = 1'b0;
        end
        if (S_AXI_ARVALID && S_AXI_ARREADY) begin
            rdata_d  = regs_q[S_AXI_ARADDR[3:2]];
            rvalid_d = 1'b1;
        end
    end

    always_ff @(posedge ACLK) begin
        if (!ARESETN) begin
            regs_q    <= '0;
            aw_full_q <= 1'b0;
            aw_idx_q  <= '0;
            w_full_q  <= 1'b0;
            w_data_q  <= '0;
            w_strb_q  <= '0;
            bvalid_q  <= 1'b0;
            rvalid_q  <= 1'b0;
            rdata_q   <= '0;
        end else begin
            regs_q    <= regs_d;
            aw_full_q <= aw_full_d;
            aw_idx_q  <= aw_idx_d;
            w_full_q  <= w_full_d;
            w_data_q  <= w_data_d;
            w_strb_q  <= w_strb_d;
            bvalid_q  <= bvalid_d;
            rvalid_q  <= rvalid_d;
            rdata_q   <= rdata_d;
        end
    end

endmodule

// File: tb/tb_ro_sync_100_s00_axi_regs.sv
// Testbench for ro_sync_100_s00_axi_regs: directed scenarios plus random
// traffic, with B/R responses checked by a scoreboard monitor against a
// register-array reference model.
module tb_ro_sync_100_s00_axi_regs;

    logic        ACLK = 1'b0;
    logic        ARESETN;
    logic [3:0]  S_AXI_AWADDR;
    logic [2:0]  S_AXI_AWPROT;
    logic        S_AXI_AWVALID;
    logic        S_AXI_AWREADY;
    logic [31:0] S_AXI_WDATA;
    logic [3:0]  S_AXI_WSTRB;
    logic        S_AXI_WVALID;
    logic        S_AXI_WREADY;
    logic [1:0]  S_AXI_BRESP;
    logic        S_AXI_BVALID;
    logic        S_AXI_BREADY;
    logic [3:0]  S_AXI_ARADDR;
    logic [2:0]  S_AXI_ARPROT;
    logic        S_AXI_ARVALID;
    logic        S_AXI_ARREADY;
    logic [31:0] S_AXI_RDATA;
    logic [1:0]  S_AXI_RRESP;
    logic        S_AXI_RVALID;
    logic        S_AXI_RREADY;
    logic [31:0] reg0_o, reg1_o, reg2_o, reg3_o;

    ro_sync_100_s00_axi_regs #(
        .C_S_AXI_DATA_WIDTH(32),
        .C_S_AXI_ADDR_WIDTH(4)
    ) dut (
        .ACLK(ACLK), .ARESETN(ARESETN),
        .S_AXI_AWADDR(S_AXI_AWADDR), .S_AXI_AWPROT(S_AXI_AWPROT),
        .S_AXI_AWVALID(S_AXI_AWVALID), .S_AXI_AWREADY(S_AXI_AWREADY),
        .S_AXI_WDATA(S_AXI_WDATA), .S_AXI_WSTRB(S_AXI_WSTRB),
        .S_AXI_WVALID(S_AXI_WVALID), .S_AXI_WREADY(S_AXI_WREADY),
        .S_AXI_BRESP(S_AXI_BRESP), .S_AXI_BVALID(S_AXI_BVALID),
        .S_AXI_BREADY(S_AXI_BREADY),
        .S_AXI_ARADDR(S_AXI_ARADDR), .S_AXI_ARPROT(S_AXI_ARPROT),
        .S_AXI_ARVALID(S_AXI_ARVALID), .S_AXI_ARREADY(S_AXI_ARREADY),
        .S_AXI_RDATA(S_AXI_RDATA), .S_AXI_RRESP(S_AXI_RRESP),
        .S_AXI_RVALID(S_AXI_RVALID), .S_AXI_RREADY(S_AXI_RREADY),
        .reg0_o(reg0_o), .reg1_o(reg1_o), .reg2_o(reg2_o), .reg3_o(reg3_o)
    );

    always #5 ACLK = ~ACLK;

    int checks   = 0;
    int failures = 0;

    logic [31:0] model [4];
    logic [31:0] exp_r [$];
    logic [1:0]  exp_b [$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Scoreboard monitor: a response is consumed on the edge after a negedge
    // where VALID and READY are both high.
    always @(negedge ACLK) begin
        if (ARESETN) begin
            if (S_AXI_RVALID && S_AXI_RREADY) begin
                if (exp_r.size() == 0) begin
                    check("r_unexpected", 32'd1, 32'd0);
                end else begin
                    check("rdata", S_AXI_RDATA, exp_r.pop_front());
                    check("rresp", {30'd0, S_AXI_RRESP}, 32'd0);
                end
            end
            if (S_AXI_BVALID && S_AXI_BREADY) begin
                if (exp_b.size() == 0) begin
                    check("b_unexpected", 32'd1, 32'd0);
                end else begin
                    check("bresp", {30'd0, S_AXI_BRESP}, {30'd0, exp_b.pop_front()});
                end
            end
        end
    end

    task automatic tick();
        @(posedge ACLK);
        #1;
    endtask

    function automatic void model_write(input logic [3:0] addr, input logic [31:0] data,
                                        input logic [3:0] strb);
        for (int n = 0; n < 4; n++) begin
            if (strb[n]) model[addr[3:2]][8*n +: 8] = data[8*n +: 8];
        end
    endfunction

    // lead > 0: W presented that many cycles before AW; lead < 0: AW first.
    // b_hold: cycles BREADY is held low once BVALID is up.
    task automatic axi_write(input logic [3:0] addr, input logic [31:0] data,
                             input logic [3:0] strb, input int lead, input int b_hold);
        bit aw_done = 0, w_done = 0, aw_hs, w_hs;
        int cyc = 0;
        model_write(addr, data, strb);
        exp_b.push_back(2'b00);
        S_AXI_BREADY = (b_hold == 0);
        if (lead >= 0) begin S_AXI_WDATA = data; S_AXI_WSTRB = strb; S_AXI_WVALID = 1'b1; end
        if (lead <= 0) begin S_AXI_AWADDR = addr; S_AXI_AWVALID = 1'b1; end
        while (!(aw_done && w_done) && cyc < 50) begin
            aw_hs = S_AXI_AWVALID && S_AXI_AWREADY;
            w_hs  = S_AXI_WVALID && S_AXI_WREADY;
            tick();
            cyc++;
            if (aw_hs) begin S_AXI_AWVALID = 1'b0; aw_done = 1; end
            if (w_hs)  begin S_AXI_WVALID = 1'b0; w_done = 1; end
            if (aw_done != w_done) begin
                check("no_bvalid_half", {31'd0, S_AXI_BVALID}, 32'd0);
                if (w_done) check("wready_full", {31'd0, S_AXI_WREADY}, 32'd0);
                if (aw_done) check("awready_full", {31'd0, S_AXI_AWREADY}, 32'd0);
            end
            if (!aw_done && !S_AXI_AWVALID && cyc >= lead) begin
                S_AXI_AWADDR = addr; S_AXI_AWVALID = 1'b1;
            end
            if (!w_done && !S_AXI_WVALID && cyc >= -lead) begin
                S_AXI_WDATA = data; S_AXI_WSTRB = strb; S_AXI_WVALID = 1'b1;
            end
        end
        if (!(aw_done && w_done)) begin
            check("write_hs_timeout", 32'd1, 32'd0);
            S_AXI_AWVALID = 1'b0; S_AXI_WVALID = 1'b0;
        end
        check("bvalid_not_yet", {31'd0, S_AXI_BVALID}, 32'd0);
        tick();
        check("bvalid_latency", {31'd0, S_AXI_BVALID}, 32'd1);
        for (int i = 0; i < b_hold; i++) begin
            check("bvalid_hold", {31'd0, S_AXI_BVALID}, 32'd1);
            check("awready_bp", {31'd0, S_AXI_AWREADY}, 32'd0);
            check("wready_bp", {31'd0, S_AXI_WREADY}, 32'd0);
            tick();
        end
        S_AXI_BREADY = 1'b1;
        cyc = 0;
        while (S_AXI_BVALID && cyc < 50) begin tick(); cyc++; end
        if (S_AXI_BVALID) check("bvalid_drop_timeout", 32'd1, 32'd0);
    endtask

    task automatic axi_read(input logic [3:0] addr, input int r_hold);
        logic [31:0] e;
        bit hs = 0;
        int cyc = 0;
        e = model[addr[3:2]];
        exp_r.push_back(e);
        S_AXI_RREADY  = (r_hold == 0);
        S_AXI_ARADDR  = addr;
        S_AXI_ARVALID = 1'b1;
        while (!hs && cyc < 50) begin
            hs = S_AXI_ARREADY;
            tick();
            cyc++;
        end
        S_AXI_ARVALID = 1'b0;
        if (!hs) check("read_hs_timeout", 32'd1, 32'd0);
        check("rvalid_latency", {31'd0, S_AXI_RVALID}, 32'd1);
        for (int i = 0; i < r_hold; i++) begin
            check("rvalid_hold", {31'd0, S_AXI_RVALID}, 32'd1);
            check("arready_bp", {31'd0, S_AXI_ARREADY}, 32'd0);
            check("rdata_stable", S_AXI_RDATA, e);
            tick();
        end
        S_AXI_RREADY = 1'b1;
        cyc = 0;
        while (S_AXI_RVALID && cyc < 50) begin tick(); cyc++; end
        if (S_AXI_RVALID) check("rvalid_drop_timeout", 32'd1, 32'd0);
    endtask

    task automatic check_regs(input string tag);
        check({tag, "_reg0"}, reg0_o, model[0]);
        check({tag, "_reg1"}, reg1_o, model[1]);
        check({tag, "_reg2"}, reg2_o, model[2]);
        check({tag, "_reg3"}, reg3_o, model[3]);
    endtask

    task automatic do_reset(input int cycles);
        ARESETN = 1'b0;
        S_AXI_AWVALID = 1'b0; S_AXI_WVALID = 1'b0; S_AXI_ARVALID = 1'b0;
        S_AXI_BREADY = 1'b1;  S_AXI_RREADY = 1'b1;
        for (int i = 0; i < 4; i++) model[i] = 32'd0;
        exp_r.delete();
        exp_b.delete();
        for (int i = 0; i < cycles; i++) tick();
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_bvalid"}, {31'd0, S_AXI_BVALID}, 32'd0);
        check({tag, "_rvalid"}, {31'd0, S_AXI_RVALID}, 32'd0);
        check({tag, "_rdata"}, S_AXI_RDATA, 32'd0);
        check({tag, "_resps"}, {28'd0, S_AXI_BRESP, S_AXI_RRESP}, 32'd0);
        check({tag, "_readies"}, {29'd0, S_AXI_AWREADY, S_AXI_WREADY, S_AXI_ARREADY}, 32'd7);
        check_regs(tag);
    endtask

    initial begin
        logic [3:0] a;
        logic [31:0] d;
        S_AXI_AWADDR = '0; S_AXI_AWPROT = '0; S_AXI_WDATA = '0; S_AXI_WSTRB = '0;
        S_AXI_ARADDR = '0; S_AXI_ARPROT = '0;

        // Reset
        do_reset(10);
        check_idle_outputs("reset");
        ARESETN = 1'b1;
        tick();
        for (int i = 0; i < 4; i++) axi_read(4'(i * 4), 0);

        // Sequential writes and reads
        for (int i = 0; i < 4; i++) axi_write(4'(i * 4), 32'(i + 1), 4'hF, 0, 0);
        for (int i = 0; i < 4; i++) axi_read(4'(i * 4), 0);
        check_regs("seq");
        check("seq_reg3_const", reg3_o, 32'd4);

        // Channel skew both ways
        axi_write(4'h8, 32'hDEADBEEF, 4'hF, 3, 0);
        check("skew_reg2", reg2_o, 32'hDEADBEEF);
        axi_write(4'h0, 32'hCAFEF00D, 4'hF, -2, 0);
        check("skew_reg0", reg0_o, 32'hCAFEF00D);

        // Byte strobes
        axi_write(4'h4, 32'h11223344, 4'hF, 0, 0);
        axi_write(4'h4, 32'hAABBCCDD, 4'b0101, 0, 0);
        check("strb_reg1", reg1_o, 32'h11BB33DD);
        axi_read(4'h4, 0);
        axi_write(4'h5, 32'hFFFFFFFF, 4'h0, 1, 0);
        check("strb0_reg1", reg1_o, 32'h11BB33DD);
        axi_read(4'h7, 0);

        // Backpressure on B and R
        axi_write(4'hC, 32'h00000004, 4'hF, 0, 5);
        axi_read(4'h8, 5);

        // Read/write collision on reg3: AR handshake on the commit edge
        exp_b.push_back(2'b00);
        exp_r.push_back(32'h00000004);
        S_AXI_AWADDR = 4'hC; S_AXI_AWVALID = 1'b1;
        S_AXI_WDATA = 32'h5; S_AXI_WSTRB = 4'hF; S_AXI_WVALID = 1'b1;
        tick();
        S_AXI_AWVALID = 1'b0; S_AXI_WVALID = 1'b0;
        S_AXI_ARADDR = 4'hC; S_AXI_ARVALID = 1'b1;
        tick();
        S_AXI_ARVALID = 1'b0;
        check("coll_bvalid", {31'd0, S_AXI_BVALID}, 32'd1);
        check("coll_rvalid", {31'd0, S_AXI_RVALID}, 32'd1);
        tick();
        tick();
        model[3] = 32'h5;
        axi_read(4'hC, 0);

        // Random traffic
        for (int i = 0; i < 60; i++) begin
            a = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 1) == 0) begin
                d = $urandom();
                axi_write(a, d, 4'($urandom_range(0, 15)), $urandom_range(0, 6) - 3,
                          ($urandom_range(0, 4) == 0) ? 2 : 0);
            end else begin
                axi_read(a, ($urandom_range(0, 4) == 0) ? 3 : 0);
            end
        end
        check_regs("rand");

        // Reset while a write response is pending
        S_AXI_BREADY = 1'b0;
        S_AXI_AWADDR = 4'h0; S_AXI_AWVALID = 1'b1;
        S_AXI_WDATA = 32'h12345678; S_AXI_WSTRB = 4'hF; S_AXI_WVALID = 1'b1;
        tick();
        S_AXI_AWVALID = 1'b0; S_AXI_WVALID = 1'b0;
        tick();
        check("rst_pre_bvalid", {31'd0, S_AXI_BVALID}, 32'd1);
        do_reset(1);
        check_idle_outputs("midrst");
        ARESETN = 1'b1;
        tick();
        check("midrst_no_b", {31'd0, S_AXI_BVALID}, 32'd0);
        axi_read(4'h0, 0);

        check("exp_r_drained", 32'(exp_r.size()), 32'd0);
        check("exp_b_drained", 32'(exp_b.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
